// File: rtl/crc32_enc_arb.sv
// Round-robin arbiter feeding one shared CRC32 encoder.
// Holds the granted payload until the checksum is handed back.
module crc32_enc_arb #(
  parameter int DATA_WIDTH = 512,
  parameter int CRC_WIDTH  = 32,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 15,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          enc_valid_o,
  output logic [DATA_WIDTH-1:0]         enc_data_o,
  input  logic                          enc_valid_i,
  input  logic [CRC_WIDTH-1:0]          enc_checksum_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_W-1:0]               rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic [CRC_WIDTH-1:0]          rsp_checksum_o,
  output logic                          busy_o,
  output logic                          timeout_err_o
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t                state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       hold_id;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [7:0]            cnt;

  logic                  gnt_any;
  logic [ID_W-1:0]       gnt_id;
  logic [ID_W:0]         idx;
  logic [ID_W-1:0]       nxt_id;

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int o = NUM_REQ - 1; o >= 0; o--) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(o);
      if (idx >= (ID_W+1)'(NUM_REQ)) begin
        idx = idx - (ID_W+1)'(NUM_REQ);
      end
      if (req_valid_i[idx[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
  end

  assign nxt_id = (hold_id == ID_W'(NUM_REQ - 1))
                ? '0 : hold_id + ID_W'(1);

  assign req_ready_o = (state == IDLE && gnt_any)
                     ? (NUM_REQ'(1) << gnt_id) : '0;

  assign busy_o     = (state != IDLE);
  assign enc_data_o = hold_data;
  assign rsp_id_o   = hold_id;
  assign rsp_data_o = hold_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      hold_id        <= '0;
      hold_data      <= '0;
      cnt            <= '0;
      enc_valid_o    <= 1'b0;
      rsp_valid_o    <= 1'b0;
      rsp_checksum_o <= '0;
      timeout_err_o  <= 1'b0;
    end else begin
      enc_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            hold_id     <= gnt_id;
            hold_data   <= req_data_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            enc_valid_o <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (enc_valid_i) begin
            rsp_checksum_o <= enc_checksum_i;
            rsp_valid_o    <= 1'b1;
            state          <= RESP;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            timeout_err_o <= 1'b1;
            rr_ptr        <= nxt_id;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rr_ptr      <= nxt_id;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/crc32_enc_arb.md
CRC32_ENC_ARB -- requirements
Module: crc32_enc_arb

Interface
REQ-001 Parameter DATA_WIDTH, default 512, payload width per request.
REQ-002 Parameter CRC_WIDTH, default 32, checksum width.
REQ-003 Parameter NUM_REQ, default 4, number of requesters, legal range 2..16; ID_W = $clog2(NUM_REQ).
REQ-004 Parameter TIMEOUT, default 15, maximum WAIT cycles before abort, legal range 1..255.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-008 req_data_i  input  NUM_REQ*DATA_WIDTH  requester k payload at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 req_ready_o  output  NUM_REQ  one-hot acceptance; requester k is accepted when bit k and req_valid_i[k] are both high.
REQ-010 enc_valid_o  output  1  issue strobe to the shared CRC32 encoder.
REQ-011 enc_data_o  output  DATA_WIDTH  payload to the encoder, held stable from issue until the encoder returns.
REQ-012 enc_valid_i  input  1  encoder result valid, nominally 1 cycle after enc_valid_o.
REQ-013 enc_checksum_i  input  CRC_WIDTH  encoder checksum, sampled only when enc_valid_i=1.
REQ-014 rsp_valid_o / rsp_ready_i  output / input  1 / 1  result handshake.
REQ-015 rsp_id_o, rsp_data_o, rsp_checksum_o  output  ID_W, DATA_WIDTH, CRC_WIDTH  requester index, payload, and checksum of the result.
REQ-016 busy_o  output  1  high in every state except IDLE.
REQ-017 timeout_err_o  output  1  sticky flag, set on an encoder timeout.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and RESP.
REQ-019 In IDLE with any req_valid_i set, the block SHALL grant round-robin starting at rr_ptr, assert exactly that req_ready_o bit for one cycle, latch the id and payload into the hold register, and move to ISSUE.
REQ-020 req_ready_o SHALL be all-zero in every state other than the accepting IDLE cycle.
REQ-021 In ISSUE, enc_valid_o SHALL be 1 for exactly one cycle, with enc_data_o taken from the hold register, and the FSM SHALL move to WAIT.
REQ-022 enc_data_o SHALL equal the hold register in ISSUE, WAIT and RESP.
REQ-023 In WAIT, on enc_valid_i=1 the block SHALL capture enc_checksum_i into rsp_checksum_o, assert rsp_valid_o and move to RESP.
REQ-024 In RESP, rsp_valid_o, rsp_id_o, rsp_data_o and rsp_checksum_o SHALL hold stable until rsp_ready_i=1.
REQ-025 On the RESP handshake the block SHALL set rr_ptr to (granted id + 1) mod NUM_REQ and return to IDLE; a new grant is possible on the following cycle.
REQ-026 Nominal latency SHALL be: accept at T, enc_valid_o at T+1, enc_valid_i at T+2, rsp_valid_o at T+3; minimum spacing between grants is 4 cycles.
REQ-027 The WAIT cycle counter SHALL clear on entry to WAIT.
REQ-028 If the counter reaches TIMEOUT without enc_valid_i, the block SHALL set timeout_err_o, produce no response, advance rr_ptr as on a handshake, and return to IDLE.
REQ-029 enc_valid_i arriving in any state other than WAIT SHALL be ignored and SHALL NOT change the FSM.
REQ-030 A request deasserted before its grant SHALL be lost without side effects; requesters hold req_valid_i until accepted.
REQ-031 A requester with req_valid_i continuously high SHALL be granted within NUM_REQ grants (no starvation).
REQ-032 timeout_err_o SHALL clear only on reset.

Reset
REQ-033 On rst_n low, regardless of the current state, the block SHALL immediately force: state=IDLE, rr_ptr=0, req_ready_o=0, enc_valid_o=0, rsp_valid_o=0, busy_o=0, timeout_err_o=0, WAIT counter=0.
REQ-034 On reset, rsp_id_o, rsp_data_o, rsp_checksum_o and the hold register SHALL be 0.
REQ-035 A transaction in flight when reset asserts SHALL be discarded, and a late enc_valid_i after reset release SHALL be ignored.

Verification
REQ-036 Single request: req_valid_i=4'b0100, data=D -> req_ready_o=4'b0100 at T, enc_valid_o at T+1 with D, rsp_valid_o at T+3 with id=2, rsp_data_o=D, rsp_checksum_o=CRC32(D).
REQ-037 All four requesters valid continuously, rsp_ready_i=1 -> grant order 0,1,2,3,0; responses spaced 4 cycles apart.
REQ-038 Backpressure: rsp_ready_i=0 for 10 cycles -> rsp_* held stable, req_ready_o=0 and enc_valid_o=0 throughout; next grant goes to id+1.
REQ-039 Encoder model never returns enc_valid_i -> timeout_err_o=1 exactly TIMEOUT cycles after WAIT entry, no rsp_valid_o, FSM back in IDLE, next request serviced normally.
REQ-040 rst_n pulsed low during WAIT, with enc_valid_i arriving 1 cycle after release -> all outputs at reset values, no response, rr_ptr=0.
REQ-041 Spurious enc_valid_i in IDLE or RESP -> no state change and rsp_checksum_o unchanged.
